// File: rtl/soc_boot_pkg.sv
// soc_boot_pkg: shared definitions for the SoC boot controller.
//   boot_state_e   - sequencer states (IDLE/HOLD_RST/SETTLE/RUN)
//   REG_*          - register index (wbs_adr_i[3:2]) inside the 16-byte window
//   CTRL_*         - bit positions inside the CTRL register
//   HOLD_RST_VAL   - reset value of the HOLD register
//   hold_load()    - counter load value for HOLD_RST (a zero HOLD still holds one cycle)
package soc_boot_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_HOLD_RST = 2'd1,
    ST_SETTLE   = 2'd2,
    ST_RUN      = 2'd3
  } boot_state_e;

  localparam logic [1:0] REG_CTRL    = 2'd0;
  localparam logic [1:0] REG_HOLD    = 2'd1;
  localparam logic [1:0] REG_STATUS  = 2'd2;
  localparam logic [1:0] REG_SCRATCH = 2'd3;

  localparam int CTRL_START        = 0;
  localparam int CTRL_STOP         = 1;
  localparam int CTRL_CLK_SEL      = 2;
  localparam int CTRL_EXT_FETCH_EN = 3;

  localparam logic [15:0] HOLD_RST_VAL = 16'h0010;

  function automatic logic [15:0] hold_load(input logic [15:0] hold);
    return (hold == 16'd0) ? 16'd1 : hold;
  endfunction

endpackage

// File: rtl/soc_boot_wb_regs.sv
// soc_boot_wb_regs: Wishbone classic slave decode + register file.
//   wbs_*         - Wishbone slave port; registered ack one cycle after a hit,
//                   never on two consecutive cycles
//   stat_state/   - live sequencer state and counter, read back via STATUS
//   stat_cnt
//   start_pulse/  - one-cycle command pulses, high during the ack cycle of the
//   stop_pulse      CTRL write that set them
//   clk_sel, ext_fetch_en, hold_cycles - R/W configuration fields
module soc_boot_wb_regs
  import soc_boot_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  input  logic [1:0]  stat_state,
  input  logic [15:0] stat_cnt,
  output logic        start_pulse,
  output logic        stop_pulse,
  output logic        clk_sel,
  output logic        ext_fetch_en,
  output logic [15:0] hold_cycles
);

  logic        hit, wr, ctrl_wr;
  logic [1:0]  reg_idx;
  logic [31:0] scratch, rdata;
  logic        unused_adr;

  assign unused_adr = ^wbs_adr_i[1:0];

  // Masking with the current ack leaves a dead cycle after every ack, so a
  // master holding stb across transfers sees at most one transfer per 2 cycles.
  assign hit     = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o &
                   (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign wr      = hit & wbs_we_i;
  assign reg_idx = wbs_adr_i[3:2];
  assign ctrl_wr = wr & (reg_idx == REG_CTRL) & wbs_sel_i[0];

  always_comb begin
    rdata = '0;
    case (reg_idx)
      REG_CTRL: begin
        rdata[CTRL_CLK_SEL]      = clk_sel;
        rdata[CTRL_EXT_FETCH_EN] = ext_fetch_en;
      end
      REG_HOLD:    rdata = {16'h0, hold_cycles};
      REG_STATUS:  rdata = {stat_cnt, 14'h0, stat_state};
      default:     rdata = scratch;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wbs_ack_o    <= 1'b0;
      wbs_dat_o    <= '0;
      start_pulse  <= 1'b0;
      stop_pulse   <= 1'b0;
      clk_sel      <= 1'b0;
      ext_fetch_en <= 1'b0;
      hold_cycles  <= HOLD_RST_VAL;
      scratch      <= '0;
    end else begin
      wbs_ack_o   <= hit;
      wbs_dat_o   <= (hit && !wbs_we_i) ? rdata : '0;
      start_pulse <= ctrl_wr & wbs_dat_i[CTRL_START];
      stop_pulse  <= ctrl_wr & wbs_dat_i[CTRL_STOP];
      if (ctrl_wr) begin
        clk_sel      <= wbs_dat_i[CTRL_CLK_SEL];
        ext_fetch_en <= wbs_dat_i[CTRL_EXT_FETCH_EN];
      end
      if (wr && reg_idx == REG_HOLD) begin
        if (wbs_sel_i[0]) hold_cycles[7:0]  <= wbs_dat_i[7:0];
        if (wbs_sel_i[1]) hold_cycles[15:8] <= wbs_dat_i[15:8];
      end
      if (wr && reg_idx == REG_SCRATCH) begin
        for (int b = 0; b < 4; b++)
          if (wbs_sel_i[b]) scratch[8*b +: 8] <= wbs_dat_i[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/soc_boot_ctrl.sv
// soc_boot_ctrl: SoC boot sequencer behind a Wishbone register window.
//   wb_clk_i/wb_rst_i - clock, async active-high reset
//   wbs_*             - Wishbone classic slave (see soc_boot_wb_regs)
//   ext_fetch_i       - pad fetch enable, used in RUN when EXT_FETCH_EN=1
//   core_rst_n_o      - core reset, released in SETTLE and RUN
//   fetch_enable_o    - core fetch enable, only in RUN
//   clk_sel_o         - clock source select from CTRL
//   boot_irq_o        - one-cycle pulse in the first RUN cycle
// Sequence: IDLE -START-> HOLD_RST (max(HOLD,1) cycles) -> SETTLE
// (SETTLE_CYCLES cycles) -> RUN. STOP returns to IDLE from anywhere.
module soc_boot_ctrl
  import soc_boot_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR     = 32'h3000_0000,
  parameter int          SETTLE_CYCLES = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  input  logic        ext_fetch_i,
  output logic        core_rst_n_o,
  output logic        fetch_enable_o,
  output logic        clk_sel_o,
  output logic        boot_irq_o
);

  localparam logic [15:0] SETTLE_LOAD = 16'(SETTLE_CYCLES);

  boot_state_e state, state_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic        start_pulse, stop_pulse, clk_sel, ext_fetch_en;
  logic [15:0] hold_cycles;

  soc_boot_wb_regs #(.BASE_ADDR(BASE_ADDR)) u_regs (
    .wb_clk_i     (wb_clk_i),
    .wb_rst_i     (wb_rst_i),
    .wbs_stb_i    (wbs_stb_i),
    .wbs_cyc_i    (wbs_cyc_i),
    .wbs_we_i     (wbs_we_i),
    .wbs_sel_i    (wbs_sel_i),
    .wbs_adr_i    (wbs_adr_i),
    .wbs_dat_i    (wbs_dat_i),
    .wbs_ack_o    (wbs_ack_o),
    .wbs_dat_o    (wbs_dat_o),
    .stat_state   (state),
    .stat_cnt     (cnt),
    .start_pulse  (start_pulse),
    .stop_pulse   (stop_pulse),
    .clk_sel      (clk_sel),
    .ext_fetch_en (ext_fetch_en),
    .hold_cycles  (hold_cycles)
  );

  assign clk_sel_o = clk_sel;  // already a flop in the register file

  // STOP is checked first so a combined START|STOP write lands in IDLE.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (stop_pulse) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        ST_IDLE: if (start_pulse) begin
          state_nxt = ST_HOLD_RST;
          cnt_nxt   = hold_load(hold_cycles);
        end
        ST_HOLD_RST: if (cnt <= 16'd1) begin
          state_nxt = ST_SETTLE;
          cnt_nxt   = SETTLE_LOAD;
        end else cnt_nxt = cnt - 16'd1;
        ST_SETTLE: if (cnt <= 16'd1) begin
          state_nxt = ST_RUN;
          cnt_nxt   = '0;
        end else cnt_nxt = cnt - 16'd1;
        default: ;
      endcase
    end
  end

  // Outputs are registered from the next state so they switch in the same
  // cycle as the state itself; ext_fetch_i is sampled here, hence its delay.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      core_rst_n_o   <= 1'b0;
      fetch_enable_o <= 1'b0;
      boot_irq_o     <= 1'b0;
    end else begin
      state          <= state_nxt;
      cnt            <= cnt_nxt;
      core_rst_n_o   <= (state_nxt == ST_SETTLE) || (state_nxt == ST_RUN);
      fetch_enable_o <= (state_nxt == ST_RUN) && (ext_fetch_en ? ext_fetch_i : 1'b1);
      boot_irq_o     <= (state_nxt == ST_RUN) && (state != ST_RUN);
    end
  end

endmodule

// File: tb/tb_soc_boot_ctrl.sv
// tb_soc_boot_ctrl: scoreboard bench for soc_boot_ctrl. Expected read data is
// queued when a bus access is issued and popped by a monitor on every ack.
module tb_soc_boot_ctrl;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        wb_clk_i = 1'b0, wb_rst_i = 1'b1;
  logic        wbs_stb_i = 1'b0, wbs_cyc_i = 1'b0, wbs_we_i = 1'b0;
  logic [3:0]  wbs_sel_i = 4'h0;
  logic [31:0] wbs_adr_i = '0, wbs_dat_i = '0;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        ext_fetch_i = 1'b0;
  logic        core_rst_n_o, fetch_enable_o, clk_sel_o, boot_irq_o;

  soc_boot_ctrl #(.BASE_ADDR(BASE), .SETTLE_CYCLES(16)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .ext_fetch_i(ext_fetch_i), .core_rst_n_o(core_rst_n_o),
    .fetch_enable_o(fetch_enable_o), .clk_sel_o(clk_sel_o), .boot_irq_o(boot_irq_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int n_run = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  typedef struct { bit rd; logic [31:0] d; } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  logic prev_ack = 1'b0;

  // Ack monitor: pops one expectation per ack, checks read data and ack spacing.
  always @(negedge wb_clk_i) begin
    if (wbs_ack_o) begin
      chk("ack_gap", {31'b0, prev_ack}, 32'h0);
      if (exp_q.size() == 0) chk("unexp_ack", 32'h1, 32'h0);
      else begin
        mon_e = exp_q.pop_front();
        if (mon_e.rd) chk("rdata", wbs_dat_o, mon_e.d);
      end
    end
    prev_ack = wbs_ack_o;
  end

  task automatic bus(input logic [31:0] a, input logic we, input logic [31:0] d,
                     input logic [3:0] sel, output logic acked);
    @(negedge wb_clk_i);
    wbs_adr_i = a; wbs_we_i = we; wbs_dat_i = d; wbs_sel_i = sel;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
    acked = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge wb_clk_i);
      if (wbs_ack_o) begin acked = 1'b1; break; end
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
  endtask

  task automatic wb_wr(input logic [7:0] off, input logic [31:0] d, input logic [3:0] sel = 4'hF);
    logic ok;
    exp_t e;
    e.rd = 1'b0; e.d = '0;
    exp_q.push_back(e);
    bus(BASE + 32'(off), 1'b1, d, sel, ok);
    chk("wr_ack", {31'b0, ok}, 32'h1);
  endtask

  task automatic wb_rd(input logic [7:0] off, input logic [31:0] exp);
    logic ok;
    exp_t e;
    e.rd = 1'b1; e.d = exp;
    exp_q.push_back(e);
    bus(BASE + 32'(off), 1'b0, '0, 4'hF, ok);
    chk("rd_ack", {31'b0, ok}, 32'h1);
  endtask

  // Measures a boot from the cycle after the START write's ack until fetch rises.
  task automatic meas_seq(output int hold_len, output int settle_len, output int irq_cnt);
    int n;
    hold_len = 0; settle_len = 0; irq_cnt = 0;
    for (n = 0; n < 300; n++) begin
      @(negedge wb_clk_i);
      if (boot_irq_o) irq_cnt++;
      if (!core_rst_n_o) hold_len++;
      else if (!fetch_enable_o) settle_len++;
      else break;
    end
    if (n == 300) chk("seq_timeout", 32'h1, 32'h0);
    repeat (3) begin
      @(negedge wb_clk_i);
      if (boot_irq_o) irq_cnt++;
    end
  endtask

  int h, s, q, acks, cnt_hi;
  logic ok;

  initial begin
    // reset state
    repeat (3) @(negedge wb_clk_i);
    chk("rst_core_rst_n", {31'b0, core_rst_n_o}, 32'h0);
    chk("rst_fetch", {31'b0, fetch_enable_o}, 32'h0);
    chk("rst_clk_sel", {31'b0, clk_sel_o}, 32'h0);
    chk("rst_irq", {31'b0, boot_irq_o}, 32'h0);
    chk("rst_ack", {31'b0, wbs_ack_o}, 32'h0);
    chk("rst_dat", wbs_dat_o, 32'h0);
    wb_rst_i = 1'b0;
    wb_rd(8'h4, 32'h0000_0010);
    wb_rd(8'h8, 32'h0);
    chk("idle_core_rst_n", {31'b0, core_rst_n_o}, 32'h0);

    // full boot, HOLD=5
    wb_wr(8'h4, 32'h5);
    wb_wr(8'h0, 32'h1);
    meas_seq(h, s, q);
    chk("boot_hold_len", 32'(h), 32'd5);
    chk("boot_settle_len", 32'(s), 32'd16);
    chk("boot_irq_cnt", 32'(q), 32'd1);
    wb_rd(8'h8, 32'h3);

    // START while running is ignored
    wb_wr(8'h0, 32'h1);
    cnt_hi = 0;
    repeat (5) begin
      @(negedge wb_clk_i);
      if (boot_irq_o || !core_rst_n_o) cnt_hi++;
    end
    chk("run_start_ignored", 32'(cnt_hi), 32'd0);

    // HOLD=0 -> one hold cycle
    wb_wr(8'h0, 32'h2);
    @(negedge wb_clk_i);
    chk("stop_core_rst_n", {31'b0, core_rst_n_o}, 32'h0);
    wb_wr(8'h4, 32'h0);
    wb_wr(8'h0, 32'h1);
    meas_seq(h, s, q);
    chk("hold0_len", 32'(h), 32'd1);
    chk("hold0_settle", 32'(s), 32'd16);
    wb_wr(8'h0, 32'h2);

    // STOP|START during SETTLE
    wb_wr(8'h4, 32'h2);
    wb_wr(8'h0, 32'h1);
    for (int i = 0; i < 20 && !core_rst_n_o; i++) @(negedge wb_clk_i);
    chk("reach_settle", {31'b0, core_rst_n_o}, 32'h1);
    repeat (2) @(negedge wb_clk_i);
    wb_wr(8'h0, 32'h3);
    @(negedge wb_clk_i);
    chk("settle_stop_rst_n", {31'b0, core_rst_n_o}, 32'h0);
    cnt_hi = 0;
    repeat (25) begin
      @(negedge wb_clk_i);
      if (boot_irq_o || core_rst_n_o || fetch_enable_o) cnt_hi++;
    end
    chk("settle_stop_quiet", 32'(cnt_hi), 32'd0);
    wb_rd(8'h8, 32'h0);

    // external fetch gating
    ext_fetch_i = 1'b0;
    wb_wr(8'h0, 32'h9);
    q = 0;
    for (int i = 0; i < 100 && q == 0; i++) begin
      @(negedge wb_clk_i);
      if (boot_irq_o) q = 1;
    end
    chk("ext_irq_seen", 32'(q), 32'd1);
    chk("ext_fetch_low", {31'b0, fetch_enable_o}, 32'h0);
    @(posedge wb_clk_i); #1 ext_fetch_i = 1'b1;
    @(negedge wb_clk_i);
    chk("ext_fetch_delay", {31'b0, fetch_enable_o}, 32'h0);
    @(negedge wb_clk_i);
    chk("ext_fetch_follow", {31'b0, fetch_enable_o}, 32'h1);

    // CTRL readback and clk_sel
    wb_wr(8'h0, 32'hC);
    @(negedge wb_clk_i);
    chk("clk_sel_out", {31'b0, clk_sel_o}, 32'h1);
    wb_rd(8'h0, 32'hC);

    // SCRATCH byte lanes, STATUS write ignored
    wb_wr(8'hC, 32'hDEAD_BEEF);
    wb_wr(8'hC, 32'h1122_3344, 4'b0101);
    wb_rd(8'hC, 32'hDE22_BE44);
    wb_wr(8'h8, 32'hFFFF_FFFF);
    wb_rd(8'h8, 32'h3);

    // miss: window + 0x10
    bus(BASE + 32'h10, 1'b0, '0, 4'hF, ok);
    chk("miss_noack", {31'b0, ok}, 32'h0);

    // back-to-back hits with stb held
    repeat (3) begin
      mon_e.rd = 1'b1; mon_e.d = 32'hDE22_BE44;
      exp_q.push_back(mon_e);
    end
    @(negedge wb_clk_i);
    wbs_adr_i = BASE + 32'hC; wbs_we_i = 1'b0; wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
    acks = 0;
    repeat (6) begin
      @(negedge wb_clk_i);
      if (wbs_ack_o) acks++;
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    chk("b2b_acks", 32'(acks), 32'd3);
    repeat (2) @(negedge wb_clk_i);

    // async reset mid-run
    @(posedge wb_clk_i); #2 wb_rst_i = 1'b1;
    #1;
    chk("async_rst_n", {31'b0, core_rst_n_o}, 32'h0);
    chk("async_fetch", {31'b0, fetch_enable_o}, 32'h0);
    chk("async_clk_sel", {31'b0, clk_sel_o}, 32'h0);
    @(negedge wb_clk_i); wb_rst_i = 1'b0;
    wb_rd(8'h4, 32'h10);
    wb_rd(8'hC, 32'h0);
    wb_rd(8'h8, 32'h0);

    repeat (3) @(negedge wb_clk_i);
    chk("q_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
